// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle MIPS control FSM: states, opcodes, datapath select encodings.
// Pure declarations; no logic, no latency, no backpressure.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ   = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;
    localparam logic [5:0] OP_ADDI   = 6'd8;
    localparam logic [5:0] OP_ADDIU  = 6'd9;
    localparam logic [5:0] OP_SLTI   = 6'd10;
    localparam logic [5:0] OP_SLTIU  = 6'd11;
    localparam logic [5:0] OP_ANDI   = 6'd12;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_XORI   = 6'd14;
    localparam logic [5:0] OP_LUI    = 6'd15;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       i_or_d;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       bus_err;
    } ctl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-FSM <-> datapath/memory bundle; master = FSM side, slave = datapath side.
// Perf counter signals exist only when MC_PERF_CNT_EN is defined.
interface mc_ctrl_fsm_if;

    logic [5:0]  op;
    logic        bflag;
    logic        mem_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic        i_or_d;
    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        reg_wr;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        illegal_op;
    logic        bus_err;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    modport master (
        input  op, bflag, mem_ready,
        output mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err
`ifdef MC_PERF_CNT_EN
        , output cyc_cnt, ret_cnt
`endif
    );

    modport slave (
        output op, bflag, mem_ready,
        input  mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err
`ifdef MC_PERF_CNT_EN
        , input cyc_cnt, ret_cnt
`endif
    );

endinterface

// File: rtl/mc_ctrl_fsm_op_class.sv
// Opcode classifier: maps instr[31:26] to an instruction class.
// Purely combinational, zero latency, no backpressure.
module mc_op_class
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    output op_class_e  cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (op_i)
            OP_RTYPE:                                 cls_o = CLS_R;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:         cls_o = CLS_I_ALU;
            OP_LW:                                    cls_o = CLS_LOAD;
            OP_SW:                                    cls_o = CLS_STORE;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_BGTZ:                                  cls_o = CLS_BRANCH;
            OP_J, OP_JAL:                             cls_o = CLS_JUMP;
            default:                                  cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM; R/I/sw 4 cycles, lw 5, branch/jump 3 with zero memory wait.
// Memory states stall on mem_ready, bounded by TIMEOUT_CYC (0 = unbounded); MC_PERF_CNT_EN adds cyc/ret counters.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
(
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_class_e     cls;
    ctl_t          ctl;
    logic          mem_wait;

    mc_op_class u_op_class (
        .op_i  (bus.op),
        .cls_o (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        ctl      = '0;
        mem_wait = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_rd    = 1'b1;
                ctl.alu_src_b = ALUB_FOUR;
                ctl.ir_wr     = bus.mem_ready;
                ctl.pc_wr     = bus.mem_ready;
                mem_wait      = 1'b1;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut
                ctl.alu_src_b = ALUB_IMM_SH2;
                case (cls)
                    CLS_R:               state_d = S_EXEC_R;
                    CLS_I_ALU:           state_d = S_EXEC_I;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    CLS_JUMP:            state_d = S_JUMP;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_B;
                ctl.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_op    = ALUOP_IMM;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctl.reg_wr  = 1'b1;
                ctl.reg_dst = (cls == CLS_R);
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_IMM;
                ctl.alu_op    = ALUOP_ADD;
                state_d       = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_rd = 1'b1;
                ctl.i_or_d = 1'b1;
                mem_wait   = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_wr     = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_wr = 1'b1;
                ctl.i_or_d = 1'b1;
                mem_wait   = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ALUB_B;
                ctl.alu_op    = ALUOP_SUB;
                ctl.pc_src    = PC_SRC_ALUOUT;
                ctl.pc_wr     = bus.bflag;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_src = PC_SRC_JUMP;
                ctl.pc_wr  = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A late mem_ready on the timeout cycle still completes normally
        if (mem_wait && !bus.mem_ready) begin
            if ((TIMEOUT_CYC != 0) && (cnt_q == TO_VAL)) begin
                ctl.bus_err = 1'b1;
                state_d     = S_FETCH;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (rst) ctl = '0;
    end

    assign bus.mem_rd     = ctl.mem_rd;
    assign bus.mem_wr     = ctl.mem_wr;
    assign bus.i_or_d     = ctl.i_or_d;
    assign bus.ir_wr      = ctl.ir_wr;
    assign bus.pc_wr      = ctl.pc_wr;
    assign bus.pc_src     = ctl.pc_src;
    assign bus.reg_wr     = ctl.reg_wr;
    assign bus.reg_dst    = ctl.reg_dst;
    assign bus.mem_to_reg = ctl.mem_to_reg;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.illegal_op = ctl.illegal_op;
    assign bus.bus_err    = ctl.bus_err;

`ifdef MC_PERF_CNT_EN
    logic        retire;
    logic [31:0] cyc_cnt_q;
    logic [31:0] ret_cnt_q;

    // Illegal opcodes leave from DECODE and timeouts need !mem_ready, so neither counts
    assign retire = !rst &&
                    ((state_q inside {S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP}) ||
                     ((state_q == S_MEM_WR) && bus.mem_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            ret_cnt_q <= ret_cnt_q + 32'(retire);
        end
    end

    assign bus.cyc_cnt = cyc_cnt_q;
    assign bus.ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm built with TIMEOUT_CYC=4; directed scenarios plus random instruction streams.
module tb_mc_ctrl_fsm;

    localparam int TO = 4;
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC_R = 2, PH_EXEC_I = 3, PH_ALU_WB = 4,
                   PH_MEM_ADDR = 5, PH_MEM_RD = 6, PH_MEM_WB = 7, PH_MEM_WR = 8,
                   PH_BRANCH = 9, PH_JUMP = 10;
    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_ILL = 6;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {bus.mem_rd, bus.mem_wr, bus.i_or_d, bus.ir_wr, bus.pc_wr, bus.pc_src,
                bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.illegal_op, bus.bus_err};
    endfunction

    // Expected control word for one cycle in a given phase, straight from the control table
    function automatic logic [16:0] exp_ctl(input int ph, input logic mr, input logic bf,
                                            input logic rdst, input logic ill, input logic be);
        logic mrd, mwr, iod, irw, pcw, rw, rd, m2r, sa, il;
        logic [1:0] pcs, sb, ao;
        {mrd, mwr, iod, irw, pcw, rw, rd, m2r, sa, il} = '0;
        pcs = 2'b00; sb = 2'b00; ao = 2'b00;
        case (ph)
            PH_FETCH:    begin mrd = 1'b1; irw = mr; pcw = mr; sb = 2'b01; end
            PH_DECODE:   begin sb = 2'b11; il = ill; end
            PH_EXEC_R:   begin sa = 1'b1; sb = 2'b00; ao = 2'b10; end
            PH_EXEC_I:   begin sa = 1'b1; sb = 2'b10; ao = 2'b11; end
            PH_ALU_WB:   begin rw = 1'b1; rd = rdst; end
            PH_MEM_ADDR: begin sa = 1'b1; sb = 2'b10; end
            PH_MEM_RD:   begin mrd = 1'b1; iod = 1'b1; end
            PH_MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
            PH_MEM_WR:   begin mwr = 1'b1; iod = 1'b1; end
            PH_BRANCH:   begin sa = 1'b1; ao = 2'b01; pcs = 2'b01; pcw = bf; end
            PH_JUMP:     begin pcs = 2'b10; pcw = 1'b1; end
            default:     ;
        endcase
        return {mrd, mwr, iod, irw, pcw, pcs, rw, rd, m2r, sa, sb, ao, il, be};
    endfunction

    function automatic int cls_of(input logic [5:0] o);
        if (o == 6'd0) return C_R;
        if (o >= 6'd8 && o <= 6'd15) return C_I;
        if (o == 6'd35) return C_LD;
        if (o == 6'd43) return C_ST;
        if (o == 6'd1 || (o >= 6'd4 && o <= 6'd7)) return C_BR;
        if (o == 6'd2 || o == 6'd3) return C_J;
        return C_ILL;
    endfunction

    // Drive one cycle's inputs just after the falling edge, settle, leave outputs for sampling
    task automatic drive(input logic [5:0] o, input logic bf, input logic mr);
        @(negedge clk);
        rst = 1'b0;
        bus.op = o;
        bus.bflag = bf;
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1;
            bus.mem_ready = 1'b1;
            #1;
            n_chk++;
            if (obs() !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_outputs_%0d: got %h expected %h", i, obs(), 17'd0);
            end
        end
        drive(6'd8, 1'b0, 1'b1);
        n_chk++;
        if (!(bus.mem_rd === 1'b1 && bus.ir_wr === 1'b1 && bus.pc_wr === 1'b1)
            || obs() !== exp_ctl(PH_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL first_fetch: got %h expected %h", obs(),
                     exp_ctl(PH_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        drive(6'd8, 1'b0, 1'b1);
        drive(6'd8, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (obs() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_instr: got %h expected %h", obs(), 17'd0);
        end
    endtask

    task automatic test_addi();
        int ph[5];
        ph = '{PH_FETCH, PH_DECODE, PH_EXEC_I, PH_ALU_WB, PH_FETCH};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            logic [16:0] e;
            drive(6'd8, 1'b0, 1'b1);
            e = exp_ctl(ph[c], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL addi_cycle%0d: got %h expected %h", c + 1, obs(), e);
            end
        end
    endtask

    task automatic test_lw_wait();
        int   ph[8];
        logic mr[8];
        ph = '{PH_FETCH, PH_DECODE, PH_MEM_ADDR, PH_MEM_RD, PH_MEM_RD, PH_MEM_RD, PH_MEM_WB, PH_FETCH};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            logic [16:0] e;
            drive(6'd35, 1'b0, mr[c]);
            e = exp_ctl(ph[c], mr[c], 1'b0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL lw_wait_cycle%0d: got %h expected %h", c + 1, obs(), e);
            end
        end
    endtask

    task automatic test_branch();
        for (int b = 1; b >= 0; b--) begin
            logic bf;
            bf = (b == 1);
            do_reset();
            drive(6'd4, bf, 1'b1);
            drive(6'd4, bf, 1'b1);
            drive(6'd4, bf, 1'b0);
            n_chk++;
            if (bus.pc_wr !== bf || bus.pc_src !== 2'b01
                || obs() !== exp_ctl(PH_BRANCH, 1'b0, bf, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL branch_bflag%0d: got %h expected %h", b, obs(),
                         exp_ctl(PH_BRANCH, 1'b0, bf, 1'b0, 1'b0, 1'b0));
            end
            drive(6'd4, bf, 1'b0);
            n_chk++;
            if (obs() !== exp_ctl(PH_FETCH, 1'b0, bf, 1'b0, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL branch_return%0d: got %h expected %h", b, obs(),
                         exp_ctl(PH_FETCH, 1'b0, bf, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(6'h3F, 1'b0, 1'b1);
        drive(6'h3F, 1'b0, 1'b1);
        n_chk++;
        if (bus.illegal_op !== 1'b1 || bus.reg_wr !== 1'b0 || bus.mem_wr !== 1'b0
            || obs() !== exp_ctl(PH_DECODE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL illegal_decode: got %h expected %h", obs(),
                     exp_ctl(PH_DECODE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        drive(6'h3F, 1'b0, 1'b0);
        n_chk++;
        if (obs() !== exp_ctl(PH_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL illegal_next_fetch: got %h expected %h", obs(),
                     exp_ctl(PH_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_timeout();
`ifdef MC_PERF_CNT_EN
        logic [31:0] ret0;
`endif
        do_reset();
        drive(6'd0, 1'b0, 1'b0);
`ifdef MC_PERF_CNT_EN
        ret0 = bus.ret_cnt;
`endif
        for (int k = 1; k <= TO; k++) begin
            n_chk++;
            if (bus.bus_err !== 1'b0 || bus.ir_wr !== 1'b0 || bus.pc_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got err=%b ir_wr=%b pc_wr=%b expected 0 0 0",
                         k, bus.bus_err, bus.ir_wr, bus.pc_wr);
            end
            drive(6'd0, 1'b0, 1'b0);
        end
        n_chk++;
        if (obs() !== exp_ctl(PH_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %h expected %h", obs(),
                     exp_ctl(PH_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        drive(6'd0, 1'b0, 1'b0);
        n_chk++;
        if (obs() !== exp_ctl(PH_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_refetch: got %h expected %h", obs(),
                     exp_ctl(PH_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
`ifdef MC_PERF_CNT_EN
        n_chk++;
        if (bus.ret_cnt !== ret0) begin
            n_fail++;
            $display("FAIL timeout_ret_cnt: got %0d expected %0d", bus.ret_cnt, ret0);
        end
`endif
        // mem_ready arriving exactly on the limit cycle completes normally
        for (int k = 1; k < TO; k++) drive(6'd0, 1'b0, 1'b0);
        drive(6'd0, 1'b0, 1'b1);
        n_chk++;
        if (obs() !== exp_ctl(PH_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL timeout_ready_wins: got %h expected %h", obs(),
                     exp_ctl(PH_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [5:0] legal[12];
        int         retired;
`ifdef MC_PERF_CNT_EN
        logic [31:0] ret0;
`endif
        legal = '{6'd0, 6'd8, 6'd12, 6'd15, 6'd35, 6'd43, 6'd1, 6'd4, 6'd7, 6'd2, 6'd3, 6'd35};
        retired = 0;
        do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
`ifdef MC_PERF_CNT_EN
        ret0 = 32'd0;
`endif
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            logic       bf;
            int         c, wf, wm;
            int         plan[$];
            bit         aborted;
            op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 11)] : 6'($urandom_range(0, 63));
            bf = 1'($urandom_range(0, 1));
            wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 1) : 0;
            wm = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TO + 1) : 0;
            c  = cls_of(op);
            plan = {PH_FETCH, PH_DECODE};
            case (c)
                C_R:  plan = {plan, PH_EXEC_R, PH_ALU_WB};
                C_I:  plan = {plan, PH_EXEC_I, PH_ALU_WB};
                C_LD: plan = {plan, PH_MEM_ADDR, PH_MEM_RD, PH_MEM_WB};
                C_ST: plan = {plan, PH_MEM_ADDR, PH_MEM_WR};
                C_BR: plan = {plan, PH_BRANCH};
                C_J:  plan = {plan, PH_JUMP};
                default: ;
            endcase
            aborted = 1'b0;
            for (int p = 0; p < plan.size() && !aborted; p++) begin
                int ph;
                ph = plan[p];
                if (ph == PH_FETCH || ph == PH_MEM_RD || ph == PH_MEM_WR) begin
                    for (int k = 0; k <= TO; k++) begin
                        logic        mr, be;
                        logic [16:0] e;
                        mr = (k == ((ph == PH_FETCH) ? wf : wm));
                        be = (k == TO) && !mr;
                        drive(op, bf, mr);
                        e = exp_ctl(ph, mr, bf, 1'b0, 1'b0, be);
                        n_chk++;
                        if (obs() !== e) begin
                            n_fail++;
                            $display("FAIL rand_%0d_op%0d_ph%0d_w%0d: got %h expected %h",
                                     n, op, ph, k, obs(), e);
                        end
                        if (mr || be) begin
                            aborted = be;
                            break;
                        end
                    end
                end else begin
                    logic        mr;
                    logic [16:0] e;
                    mr = 1'($urandom_range(0, 1));
                    drive(op, bf, mr);
                    e = exp_ctl(ph, mr, bf, (c == C_R), (c == C_ILL), 1'b0);
                    n_chk++;
                    if (obs() !== e) begin
                        n_fail++;
                        $display("FAIL rand_%0d_op%0d_ph%0d: got %h expected %h", n, op, ph, obs(), e);
                    end
                end
            end
            if (!aborted && c != C_ILL) retired++;
        end
`ifdef MC_PERF_CNT_EN
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        n_chk++;
        if (bus.ret_cnt !== ret0 + 32'(retired)) begin
            n_fail++;
            $display("FAIL rand_ret_cnt: got %0d expected %0d", bus.ret_cnt, ret0 + 32'(retired));
        end
`endif
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.op = 6'd0;
        bus.bflag = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
